// File: rtl/riscv_store_checker.sv
`default_nettype none
// ============================================================================
// Module      : riscv_store_checker
// Description : End-of-test checker for the single-cycle RISC-V harness.
//               Snoops the data-memory write port. The test passes on a store
//               of PASS_DATA to PASS_ADDR. It fails on a store of any other
//               data to PASS_ADDR, or on a store outside the tolerated
//               address window. It also fails if the watchdog expires first.
//               Optional capture of the offending store is controlled by the
//               macro STORE_CHECKER_CAPTURE_EN (default: undefined, no capture).
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_store_checker #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] PASS_ADDR      = ADDR_W'(0),
  parameter logic [DATA_W-1:0] PASS_DATA      = DATA_W'(25),
  parameter logic [ADDR_W-1:0] IGNORE_LO      = ADDR_W'(96),
  parameter logic [ADDR_W-1:0] IGNORE_HI      = ADDR_W'(96),
  parameter int                TIMEOUT_CYCLES = 40,
  parameter int                CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active-low
  input  logic              clear,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  // An inverted window (HI < LO) disables the tolerated range entirely.
  localparam logic c_IGN_EN = (IGNORE_HI >= IGNORE_LO);
  // The cycle counter and the watchdog limit are compared in at least 32 bits.
  // A limit beyond the counter range then never matches a truncated count.
  localparam int   c_CMP_W  = (CNT_W > 32) ? CNT_W : 32;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cycle_count;
  logic [CNT_W-1:0]   r_store_count;
  logic               r_done;
  logic               r_pass;
  logic               r_fail;
  logic               r_timeout;
  logic               w_hit_pass;
  logic               w_data_ok;
  logic               w_in_ign;
  logic               w_wd_exp;
  logic               w_run;

  assign w_run      = (r_state == ST_RUN);
  assign w_hit_pass = (DataAdr == PASS_ADDR);
  assign w_data_ok  = (WriteData == PASS_DATA);
  assign w_in_ign   = c_IGN_EN && (DataAdr >= IGNORE_LO) && (DataAdr <= IGNORE_HI);

  // The watchdog fires in the last allowed RUN cycle (count == limit-1).
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog_on
      assign w_wd_exp = (c_CMP_W'(r_cycle_count) == c_CMP_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_wdog_off
      assign w_wd_exp = 1'b0;
    end
  endgenerate

  // State register; reset low aborts any test in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state decision. A terminating store beats the watchdog; clear beats both.
  always_comb begin
    w_state_nxt = r_state;
    if (w_run) begin
      if (MemWrite && w_hit_pass) begin
        w_state_nxt = w_data_ok ? ST_PASS : ST_FAIL;
      end else if (MemWrite && !w_in_ign) begin
        w_state_nxt = ST_FAIL;
      end else if (w_wd_exp) begin
        w_state_nxt = ST_TOUT;
      end
    end
    if (clear) w_state_nxt = ST_RUN;
  end

  // RUN cycle counter; saturates at all-ones and freezes in terminal states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= '0;
    end else if (clear) begin
      r_cycle_count <= '0;
    end else if (w_run && (r_cycle_count != '1)) begin
      r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  // Accepted-store counter; the terminating store is counted too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_store_count <= '0;
    end else if (clear) begin
      r_store_count <= '0;
    end else if (w_run && MemWrite && (r_store_count != '1)) begin
      r_store_count <= r_store_count + CNT_W'(1);
    end
  end

  // Status flags are registered from the next state, so they track r_state glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= (w_state_nxt != ST_RUN);
      r_pass    <= (w_state_nxt == ST_PASS);
      r_fail    <= (w_state_nxt == ST_FAIL) || (w_state_nxt == ST_TOUT);
      r_timeout <= (w_state_nxt == ST_TOUT);
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;
  assign store_count = r_store_count;

`ifdef STORE_CHECKER_CAPTURE_EN
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_data;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;
  logic              w_enter_fail;
  logic              w_enter_tout;

  assign w_enter_fail = w_run && (w_state_nxt == ST_FAIL);
  assign w_enter_tout = w_run && (w_state_nxt == ST_TOUT);

  // Remember the most recent accepted store for a later timeout report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_addr <= '0;
      r_last_data <= '0;
    end else if (clear) begin
      r_last_addr <= '0;
      r_last_data <= '0;
    end else if (w_run && MemWrite) begin
      r_last_addr <= DataAdr;
      r_last_data <= WriteData;
    end
  end

  // Latch the offending store on FAIL entry, or the last accepted store on TOUT entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (clear) begin
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (w_enter_fail || (w_enter_tout && MemWrite)) begin
      r_fail_addr <= DataAdr;
      r_fail_data <= WriteData;
    end else if (w_enter_tout) begin
      r_fail_addr <= r_last_addr;
      r_fail_data <= r_last_data;
    end
  end

  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_store_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_store_checker
// Description : Directed bench for riscv_store_checker. The main instance
//               uses the default parameters. A second instance has the
//               watchdog disabled and 4-bit counters, to exercise
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_store_checker;

`ifdef STORE_CHECKER_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        clear;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        done, pass, fail, timeout;
  logic [15:0] cycle_count, store_count;
  logic [31:0] fail_addr, fail_data;

  logic        clear2, mw2;
  logic [31:0] adr2, wd2;
  logic        done2, pass2, fail2, timeout2;
  logic [3:0]  cyc2, st2;
  logic [31:0] fa2, fd2;

  int n_cmp = 0;
  int n_err = 0;

  riscv_store_checker dut (
    .clk(clk), .reset(reset), .clear(clear), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_count(cycle_count), .store_count(store_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  riscv_store_checker #(.TIMEOUT_CYCLES(0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .clear(clear2), .MemWrite(mw2),
    .DataAdr(adr2), .WriteData(wd2),
    .done(done2), .pass(pass2), .fail(fail2), .timeout(timeout2),
    .cycle_count(cyc2), .store_count(st2),
    .fail_addr(fa2), .fail_data(fd2)
  );

  // Posedges at 10, 20, 30 ...; inputs are driven and outputs sampled on negedges.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp);
    chk({tag, "_flags"}, 64'({done, pass, fail, timeout}), 64'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int cyc, input int st);
    chk({tag, "_cyc"}, 64'(cycle_count), 64'(cyc));
    chk({tag, "_st"},  64'(store_count), 64'(st));
  endtask

  task automatic chk_cap(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_faddr"}, 64'(fail_addr), CAP ? 64'(a) : 64'(0));
    chk({tag, "_fdata"}, 64'(fail_data), CAP ? 64'(d) : 64'(0));
  endtask

  // One clock cycle with the given store request.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    clear = 1'b0;
  endtask

  // flag vector order: {done, pass, fail, timeout}
  initial begin
    reset = 1'b0; clear = 1'b0;
    MemWrite = 1'bx; DataAdr = 'x; WriteData = 'x;
    clear2 = 1'b0; mw2 = 1'b0; adr2 = '0; wd2 = '0;

    @(negedge clk); @(negedge clk);
    chk_flags("reset", 4'b0000);
    chk_cnt("reset", 0, 0);
    chk_cap("reset", 32'd0, 32'd0);

    // Release at t=25; cycle k ends at posedge 30+10k.
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 4 || c == 6) step(1'b1, 32'd96, 32'(c));
      else                            step(1'b0, 32'd0, 32'd0);
    end
    chk_flags("pre_pass", 4'b0000);
    chk_cnt("pre_pass", 10, 3);
    step(1'b1, 32'd0, 32'd25);
    chk_flags("pass", 4'b1100);
    chk_cnt("pass", 11, 4);
    // Terminal state is sticky; later stores are ignored.
    step(1'b1, 32'd100, 32'd7);
    step(1'b1, 32'd0, 32'd24);
    chk_flags("pass_sticky", 4'b1100);
    chk_cnt("pass_sticky", 11, 4);
    chk_cap("pass_sticky", 32'd0, 32'd0);

    // Clear from PASS, then rerun.
    do_clear();
    chk_flags("clear", 4'b0000);
    chk_cnt("clear", 0, 0);
    step(1'b1, 32'd96, 32'd1);
    step(1'b1, 32'd0, 32'd25);
    chk_flags("rerun", 4'b1100);
    chk_cnt("rerun", 2, 2);

    // Wrong data at the pass address.
    do_clear();
    idle(2);
    step(1'b1, 32'd0, 32'd24);
    chk_flags("bad_data", 4'b1010);
    chk_cnt("bad_data", 3, 1);
    chk_cap("bad_data", 32'd0, 32'd24);

    // Illegal address; a later good store must not rescue it.
    do_clear();
    step(1'b1, 32'd100, 32'd7);
    chk_flags("bad_addr", 4'b1010);
    chk_cap("bad_addr", 32'd100, 32'd7);
    step(1'b1, 32'd0, 32'd25);
    chk_flags("bad_addr_sticky", 4'b1010);
    chk_cnt("bad_addr_sticky", 1, 1);
    chk_cap("bad_addr_sticky", 32'd100, 32'd7);

    // Timeout with one tolerated store: capture reports that store.
    do_clear();
    idle(3);
    step(1'b1, 32'd96, 32'h55);
    idle(35);
    chk_flags("pre_tout", 4'b0000);
    chk_cnt("pre_tout", 39, 1);
    idle(1);
    chk_flags("tout", 4'b1011);
    chk_cnt("tout", 40, 1);
    chk_cap("tout", 32'd96, 32'h55);

    // Timeout with no store since clear: capture stays zero.
    do_clear();
    idle(40);
    chk_flags("tout_nostore", 4'b1011);
    chk_cap("tout_nostore", 32'd0, 32'd0);

    // Terminating store in the last cycle beats the watchdog.
    do_clear();
    idle(39);
    step(1'b1, 32'd0, 32'd25);
    chk_flags("last_cycle_pass", 4'b1100);
    chk_cnt("last_cycle_pass", 40, 1);

    // A tolerated store in the last cycle still times out and is captured.
    do_clear();
    idle(39);
    step(1'b1, 32'd96, 32'h77);
    chk_flags("last_cycle_ign", 4'b1011);
    chk_cnt("last_cycle_ign", 40, 1);
    chk_cap("last_cycle_ign", 32'd96, 32'h77);

    // Asynchronous reset from PASS, between clock edges.
    do_clear();
    step(1'b1, 32'd0, 32'd25);
    chk_flags("pre_areset", 4'b1100);
    #2 reset = 1'b0;
    #1;
    chk_flags("areset", 4'b0000);
    chk_cnt("areset", 0, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(5);
    chk_flags("post_areset", 4'b0000);
    chk_cnt("post_areset", 5, 0);
    step(1'b1, 32'd0, 32'd25);
    chk_flags("post_areset_pass", 4'b1100);
    chk_cnt("post_areset_pass", 6, 1);

    // Disabled watchdog and saturating 4-bit counter.
    idle(1000);
    chk("nowd_done", 64'(done2), 64'(0));
    chk("nowd_cyc_sat", 64'(cyc2), 64'(15));
    chk("nowd_st", 64'(st2), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_store_checker.md
Name: riscv_store_checker

Overview:
- Synthesizable end-of-test checker for the single-cycle RISC-V core's test harness.
- Snoops the core's data-memory write port and decides pass or fail from a parametrised pass signature (address/data), a set of tolerated addresses, and a cycle-timeout watchdog.
- Replaces ad-hoc bench-side store checks and hard-coded cycle counts; sits beside top's data memory, driven by the same clock and reset.

Parameters:
- ADDR_W, 32, width of DataAdr.
- DATA_W, 32, width of WriteData.
- PASS_ADDR, 0, store address that ends the test.
- PASS_DATA, 25, data required at PASS_ADDR for pass.
- IGNORE_LO, 96, lowest tolerated non-terminal store address, inclusive.
- IGNORE_HI, 96, highest tolerated non-terminal store address, inclusive; IGNORE_HI < IGNORE_LO means no tolerated range.
- TIMEOUT_CYCLES, 40, RUN cycles allowed before timeout; 0 disables the watchdog.
- CNT_W, 16, width of cycle and store counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart of the checker (returns to RUN, counters zeroed).
- MemWrite  in  1  core data-memory write strobe.
- DataAdr  in  ADDR_W  store address.
- WriteData  in  DATA_W  store data.
- done  out  1  test finished (PASS, FAIL or TIMEOUT).
- pass  out  1  finished with correct signature.
- fail  out  1  finished with wrong data, illegal store address, or timeout.
- timeout  out  1  finished because the watchdog expired.
- cycle_count  out  CNT_W  cycles spent in RUN.
- store_count  out  CNT_W  accepted stores in RUN.
- fail_addr  out  ADDR_W  address of the offending store (see Optional Feature).
- fail_data  out  DATA_W  data of the offending store (see Optional Feature).

Behaviour:
- States: RUN, PASS, FAIL, TOUT.
  - reset low forces RUN asynchronously.
  - All outputs reset to 0; counters reset to 0.
- RUN, each posedge with MemWrite=1:
  - DataAdr==PASS_ADDR and WriteData==PASS_DATA -> PASS.
  - DataAdr==PASS_ADDR and data mismatch -> FAIL.
  - DataAdr in [IGNORE_LO, IGNORE_HI] -> stay in RUN.
  - any other address -> FAIL.
  - Every MemWrite=1 cycle in RUN increments store_count, including the terminating store.
- RUN, every cycle: cycle_count increments. Both counters saturate at all-ones and do not wrap.
- Watchdog: with TIMEOUT_CYCLES>0, if cycle_count==TIMEOUT_CYCLES-1 and no terminating store occurs in that cycle -> TOUT.
  - A store that terminates the test in the same cycle takes priority over the timeout.
- Terminal states (PASS, FAIL, TOUT) are sticky; MemWrite is ignored and counters freeze.
- Outputs are registered and decoded from state, so they become valid the cycle after the deciding edge:
  - done=1 in any terminal state.
  - pass=1 only in PASS.
  - fail=1 in FAIL or TOUT.
  - timeout=1 only in TOUT.
- clear=1 at a posedge: state returns to RUN, counters go to 0, fail_addr/fail_data go to 0. clear has priority over any store or timeout in the same cycle.
- MemWrite and DataAdr may contain X before reset is released; reset low masks them.
- A reset assertion in the middle of a test aborts it immediately; no partial result is retained.

Optional Feature:
- Macro: STORE_CHECKER_CAPTURE_EN.
- Defined:
  - On entry to FAIL, fail_addr/fail_data latch DataAdr/WriteData of the offending store.
  - On entry to TOUT, they latch the last accepted store, or stay 0 if there was none.
  - Values hold until reset or clear.
- Undefined: fail_addr and fail_data are tied to 0, and no capture registers are built.

Test Plan:
- Release reset at 25 time units; stores to 96 (x3), then to 0 with data 25 at cycle 10 -> pass=1, done=1 on the next cycle, store_count=4, cycle_count=11.
- Store to 0 with data 24 -> fail=1, pass=0; with CAPTURE_EN, fail_addr=0 and fail_data=24.
- Store to 100 with data 7 -> fail=1; with CAPTURE_EN, fail_addr=100 and fail_data=7; a later store to 0 with data 25 leaves pass=0.
- No stores for 40 cycles -> timeout=1, fail=1 after cycle_count reaches 40; store in cycle 39 to 0 with data 25 -> pass=1, timeout=0.
- Pulse clear in PASS -> all flags 0 and counters 0 next cycle, then a normal rerun passes; assert reset mid-run -> outputs 0 asynchronously.
- TIMEOUT_CYCLES=0 with 1000 idle cycles -> done stays 0; with CNT_W=4, cycle_count saturates at 15.
